// File: rtl/window_scanner.sv
// Raster-order window scheduler for the detection cascade: launches one cascade run per
// window, offsets cascade reads by the window base, emits hit records. Optional watchdog: SCANNER_TIMEOUT_EN.
module window_scanner #(
  parameter int IMG_W   = 160,
  parameter int IMG_H   = 120,
  parameter int WIN     = 24,
  parameter int STEP    = 4,
  parameter int TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        cascade_detect_en,
  input  logic        cascade_detect_done,
  input  logic        cascade_detected_flag,
  input  logic [14:0] cascade_rd_addr,
  output logic [14:0] ii_rd_addr,
  output logic        hit_valid,
  input  logic        hit_ready,
  output logic [7:0]  hit_x,
  output logic [7:0]  hit_y,
  output logic        timeout_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_EMIT    = 3'd3;
  localparam logic [2:0] S_ADVANCE = 3'd4;
  localparam logic [2:0] S_DRAIN   = 3'd5;

  localparam logic [15:0] STEP_XY  = 16'(STEP);
  localparam logic [14:0] STEP_B   = 15'(STEP);
  localparam logic [14:0] ROW_STEP = 15'(STEP * IMG_W);

  logic [2:0]  state, state_nx;
  logic [15:0] x, y;
  logic [14:0] base, row_base;
  logic        x_fits, y_fits;
  logic        wd_hit;

  assign x_fits     = ({16'd0, x} + 32'(STEP + WIN)) <= 32'(IMG_W);
  assign y_fits     = ({16'd0, y} + 32'(STEP + WIN)) <= 32'(IMG_H);
  assign busy       = (state != S_IDLE);
  assign ii_rd_addr = base + cascade_rd_addr;

  // Abort outranks every other transition; a done coincident with abort in WAIT completes the drain.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start) state_nx = S_LAUNCH;
      S_LAUNCH:  state_nx = abort ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (abort)                    state_nx = cascade_detect_done ? S_IDLE : S_DRAIN;
        else if (cascade_detect_done) state_nx = cascade_detected_flag ? S_EMIT : S_ADVANCE;
        else if (wd_hit)              state_nx = S_ADVANCE;
      end
      S_EMIT: begin
        if (abort)          state_nx = S_DRAIN;
        else if (hit_ready) state_nx = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (abort)                 state_nx = S_IDLE;
        else if (x_fits || y_fits) state_nx = S_LAUNCH;
        else                       state_nx = S_IDLE;
      end
      S_DRAIN:   if (cascade_detect_done || wd_hit) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      done              <= 1'b0;
      cascade_detect_en <= 1'b0;
      hit_valid         <= 1'b0;
      hit_x             <= 8'd0;
      hit_y             <= 8'd0;
      x                 <= 16'd0;
      y                 <= 16'd0;
      base              <= 15'd0;
      row_base          <= 15'd0;
    end else begin
      state             <= state_nx;
      done              <= (state == S_ADVANCE) && !abort && !x_fits && !y_fits;
      cascade_detect_en <= (state_nx == S_LAUNCH);
      hit_valid         <= (state_nx == S_EMIT);
      if (state == S_IDLE && start) begin
        x        <= 16'd0;
        y        <= 16'd0;
        base     <= 15'd0;
        row_base <= 15'd0;
      end
      if (state == S_WAIT && !abort && cascade_detect_done && cascade_detected_flag) begin
        hit_x <= x[7:0];
        hit_y <= y[7:0];
      end
      // base only moves here, while the cascade is idle between windows
      if (state == S_ADVANCE && !abort) begin
        if (x_fits) begin
          x    <= x + STEP_XY;
          base <= base + STEP_B;
        end else if (y_fits) begin
          x        <= 16'd0;
          y        <= y + STEP_XY;
          row_base <= row_base + ROW_STEP;
          base     <= row_base + ROW_STEP;
        end
      end
    end
  end

`ifdef SCANNER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 13) ? $clog2(TIMEOUT + 1) : 13;

  logic [CNT_W-1:0] wd_cnt;
  logic             timeout_q;

  assign wd_hit      = ((state == S_WAIT) || (state == S_DRAIN)) && (wd_cnt == CNT_W'(TIMEOUT));
  assign timeout_err = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_nx == S_LAUNCH)
        wd_cnt <= '0;
      else if (((state == S_WAIT) || (state == S_DRAIN)) && !wd_hit)
        wd_cnt <= wd_cnt + 1'b1;
      if (state == S_IDLE && start)
        timeout_q <= 1'b0;
      else if (wd_hit)
        timeout_q <= 1'b1;
    end
  end
`else
  assign wd_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
